uart_param_core: RTL and testbench

Parametrised full-duplex UART core: next generation of the fixed 8-bit even-parity UART used on the DE-board top level. Adds:
- configurable data width, parity mode, stop-bit count and baud rate
- mid-bit RX sampling with start-glitch rejection
- latched parity and framing error flags, plus a sticky overrun flag

Sits between board-level GPIO pins and user logic; TX-to-RX loopback through GPIO remains the standard bring-up configuration.

---
 rtl/uart_param_core.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_param_core.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_param_core.sv
// uart_param_core: parametrised full-duplex UART with mid-bit RX sampling,
// start-glitch rejection, latched parity/framing flags and sticky overrun.
// Ports: CLOCK_50/KEY0 clock and sync active-low reset; tx_data/tx_wr_en/
// tx_busy/tx transmit side; rx/rx_data/rx_ready/rx_rdy_clr receive side;
// parity_err/frame_err/overrun status for the frame held in rx_data.
module uart_param_core #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 1,
  parameter int STOP_BITS = 1
) (
  input  logic                 CLOCK_50,
  input  logic                 KEY0,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_wr_en,
  output logic                 tx_busy,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  input  logic                 rx_rdy_clr,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);
  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = (STOP_BITS == 2);
  localparam logic       HAS_PAR   = (PARITY != 0);

  function automatic logic par_of(
    input logic [DATA_BITS-1:0] d
  );
    return (PARITY == 2) ? ~(^d) : ^d;
  endfunction

  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA, T_PAR, T_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_DONE
  } rx_state_t;

  tx_state_t            tx_st;
  logic [CW-1:0]        tx_cnt;
  logic [3:0]           tx_idx;
  logic                 tx_sidx;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par;
  logic                 tx_end;

  assign tx_end = (tx_cnt == BIT_END);

  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      tx_st   <= T_IDLE;
      tx_cnt  <= '0;
      tx_idx  <= '0;
      tx_sidx <= 1'b0;
      tx_sh   <= '0;
      tx_par  <= 1'b0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      if (tx_st != T_IDLE)
        tx_cnt <= tx_end ? '0 : tx_cnt + CW'(1);
      unique case (tx_st)
        T_IDLE: begin
          tx_cnt <= '0;
          if (tx_wr_en) begin
            tx_sh   <= tx_data;
            tx_par  <= par_of(tx_data);
            tx      <= 1'b0;
            tx_busy <= 1'b1;
            tx_st   <= T_START;
          end
        end
        T_START: if (tx_end) begin
          tx     <= tx_sh[0];
          tx_idx <= '0;
          tx_st  <= T_DATA;
        end
        T_DATA: if (tx_end) begin
          if (tx_idx == LAST_BIT) begin
            tx_sidx <= 1'b0;
            tx      <= HAS_PAR ? tx_par : 1'b1;
            tx_st   <= HAS_PAR ? T_PAR : T_STOP;
          end else begin
            tx     <= tx_sh[1];
            tx_sh  <= tx_sh >> 1;
            tx_idx <= tx_idx + 4'd1;
          end
        end
        T_PAR: if (tx_end) begin
          tx      <= 1'b1;
          tx_sidx <= 1'b0;
          tx_st   <= T_STOP;
        end
        T_STOP: if (tx_end) begin
          if (tx_sidx == LAST_STOP) begin
            tx_busy <= 1'b0;
            tx_st   <= T_IDLE;
          end else begin
            tx_sidx <= 1'b1;
          end
        end
        default: tx_st <= T_IDLE;
      endcase
    end
  end

  logic rx_m, rx_s;

  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  rx_state_t            rx_st;
  logic [CW-1:0]        rx_cnt;
  logic [3:0]           rx_idx;
  logic                 rx_sidx;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_pbit;
  logic                 rx_ferr;
  logic                 rx_end;

  assign rx_end = (rx_cnt == BIT_END);

  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      rx_st      <= R_IDLE;
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_sidx    <= 1'b0;
      rx_sh      <= '0;
      rx_pbit    <= 1'b0;
      rx_ferr    <= 1'b0;
      rx_data    <= '0;
      rx_ready   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (rx_rdy_clr) begin
        rx_ready <= 1'b0;
        overrun  <= 1'b0;
      end
      unique case (rx_st)
        R_IDLE: begin
          rx_cnt <= '0;
          if (!rx_s) begin
            rx_ferr <= 1'b0;
            rx_st   <= R_START;
          end
        end
        // half a bit in: still low means a real start bit
        R_START: begin
          if (rx_cnt == HALF_END) begin
            rx_cnt <= '0;
            rx_idx <= '0;
            rx_st  <= rx_s ? R_IDLE : R_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        R_DATA: begin
          rx_cnt <= rx_end ? '0 : rx_cnt + CW'(1);
          if (rx_end) begin
            rx_sh <= {rx_s, rx_sh[DATA_BITS-1:1]};
            if (rx_idx == LAST_BIT) begin
              rx_sidx <= 1'b0;
              rx_st   <= HAS_PAR ? R_PAR : R_STOP;
            end else begin
              rx_idx <= rx_idx + 4'd1;
            end
          end
        end
        R_PAR: begin
          rx_cnt <= rx_end ? '0 : rx_cnt + CW'(1);
          if (rx_end) begin
            rx_pbit <= rx_s;
            rx_sidx <= 1'b0;
            rx_st   <= R_STOP;
          end
        end
        R_STOP: begin
          rx_cnt <= rx_end ? '0 : rx_cnt + CW'(1);
          if (rx_end) begin
            if (!rx_s)
              rx_ferr <= 1'b1;
            if (rx_sidx == LAST_STOP)
              rx_st <= R_DONE;
            else
              rx_sidx <= 1'b1;
          end
        end
        // a clear in this cycle frees the slot for the new frame
        R_DONE: begin
          rx_st <= R_IDLE;
          if (!rx_ready || rx_rdy_clr) begin
            rx_data    <= rx_sh;
            parity_err <= HAS_PAR &&
                          (rx_pbit != par_of(rx_sh));
            frame_err  <= rx_ferr;
            rx_ready   <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end
        default: rx_st <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_param_core.sv
// tb_uart_param_core: scoreboard bench for uart_param_core across three
// builds (defaults, odd parity + 2 stops, 7N1 at 9600 baud).
`timescale 1ns/1ps
module tb_uart_param_core;

  localparam int CLK_FREQ = 50000000;
  localparam int CPB   = CLK_FREQ / 115200;
  localparam int CPB_C = CLK_FREQ / 9600;
  // frame lengths in bits: start + data + parity + stops
  localparam int NB_A = 1 + 8 + 1 + 1;
  localparam int NB_C = 1 + 7 + 0 + 1;
  // accept edge to DONE edge: two sync stages, one idle detect,
  // half a bit to the start centre, then whole bits to the last stop
  localparam int DONE_A = 4 + CPB / 2 + (NB_A - 1) * CPB;
  localparam int DONE_C = 4 + CPB_C / 2 + (NB_C - 1) * CPB_C;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_a, rst_bc;
  logic [7:0] tx_data_a, rxd_a;
  logic       wr_a, busy_a, tx_a, rx_a, drv_a, lb_a;
  logic       rdy_a, clr_a, pe_a, fe_a, ov_a;
  logic [7:0] rxd_b;
  logic       busy_b, tx_b, drv_b;
  logic       rdy_b, clr_b, pe_b, fe_b, ov_b;
  logic [6:0] tx_data_c, rxd_c;
  logic       wr_c, busy_c, tx_c;
  logic       rdy_c, clr_c, pe_c, fe_c, ov_c;

  assign rx_a = lb_a ? tx_a : drv_a;

  uart_param_core u_a (
    .CLOCK_50(clk), .KEY0(rst_a),
    .tx_data(tx_data_a), .tx_wr_en(wr_a),
    .tx_busy(busy_a), .tx(tx_a), .rx(rx_a),
    .rx_data(rxd_a), .rx_ready(rdy_a),
    .rx_rdy_clr(clr_a), .parity_err(pe_a),
    .frame_err(fe_a), .overrun(ov_a)
  );

  uart_param_core #(.PARITY(2), .STOP_BITS(2)) u_b (
    .CLOCK_50(clk), .KEY0(rst_bc),
    .tx_data(8'h00), .tx_wr_en(1'b0),
    .tx_busy(busy_b), .tx(tx_b), .rx(drv_b),
    .rx_data(rxd_b), .rx_ready(rdy_b),
    .rx_rdy_clr(clr_b), .parity_err(pe_b),
    .frame_err(fe_b), .overrun(ov_b)
  );

  uart_param_core #(
    .DATA_BITS(7), .PARITY(0), .BAUD(9600)
  ) u_c (
    .CLOCK_50(clk), .KEY0(rst_bc),
    .tx_data(tx_data_c), .tx_wr_en(wr_c),
    .tx_busy(busy_c), .tx(tx_c), .rx(tx_c),
    .rx_data(rxd_c), .rx_ready(rdy_c),
    .rx_rdy_clr(clr_c), .parity_err(pe_c),
    .frame_err(fe_c), .overrun(ov_c)
  );

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t qa[$], qb[$], qc[$];
  int checks = 0, errors = 0;
  int rises_a = 0, rises_b = 0, rises_c = 0;
  int rise_t_a = 0;
  logic pa = 1'b0, pb = 1'b0, pc = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic expect_push(input int w, input exp_t e);
    if (w == 0) qa.push_back(e);
    else if (w == 1) qb.push_back(e);
    else qc.push_back(e);
  endtask

  task automatic mon(input int w, input logic [8:0] d,
                     input logic pe, input logic fe);
    exp_t e;
    bit got;
    got = 1'b0;
    if (w == 0 && qa.size() > 0) begin
      e = qa.pop_front(); got = 1'b1;
    end else if (w == 1 && qb.size() > 0) begin
      e = qb.pop_front(); got = 1'b1;
    end else if (w == 2 && qc.size() > 0) begin
      e = qc.pop_front(); got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL unexpected_rx_%0d: rx_data %0h, none queued",
               w, d);
    end else begin
      chk($sformatf("rx_data_%0d", w), 32'(d), 32'(e.d));
      chk($sformatf("parity_err_%0d", w), 32'(pe), 32'(e.pe));
      chk($sformatf("frame_err_%0d", w), 32'(fe), 32'(e.fe));
    end
  endtask

  always @(negedge clk) begin
    if (rdy_a && !pa) begin
      rises_a++;
      rise_t_a = cyc;
      mon(0, {1'b0, rxd_a}, pe_a, fe_a);
    end
    if (rdy_b && !pb) begin
      rises_b++;
      mon(1, {1'b0, rxd_b}, pe_b, fe_b);
    end
    if (rdy_c && !pc) begin
      rises_c++;
      mon(2, {2'b0, rxd_c}, pe_c, fe_c);
    end
    pa = rdy_a; pb = rdy_b; pc = rdy_c;
  end

  function automatic int rises_of(input int w);
    return (w == 0) ? rises_a : (w == 1) ? rises_b : rises_c;
  endfunction

  task automatic wait_rise(input int w, input int n0,
                           input int lim);
    int n;
    n = 0;
    while (rises_of(w) <= n0 && n < lim) begin
      @(negedge clk); #1;
      n++;
    end
    if (rises_of(w) <= n0) begin
      checks++;
      errors++;
      $display("FAIL rx_timeout_%0d: no rx_ready in %0d cycles",
               w, lim);
    end
  endtask

  task automatic wait_idle_a();
    int n;
    n = 0;
    while (busy_a && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (busy_a) begin
      checks++;
      errors++;
      $display("FAIL tx_idle_timeout: tx_busy still 1");
    end
  endtask

  task automatic tx_send_a(input logic [7:0] d,
                           output int t0);
    wait_idle_a();
    @(negedge clk);
    tx_data_a = d;
    wr_a = 1'b1;
    @(negedge clk);
    wr_a = 1'b0;
    t0 = cyc;
  endtask

  task automatic pulse_clr(input int w);
    @(negedge clk);
    if (w == 0) clr_a = 1'b1; else clr_b = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    clr_b = 1'b0;
  endtask

  // Serialise one frame onto the driven rx line of build w and queue
  // the response the receiver owes for it.
  task automatic drive_frame(input int w, input logic [8:0] d,
                             input int nd, input int pm,
                             input bit par_ok, input int ns,
                             input logic [1:0] sv);
    logic bq[$];
    exp_t e;
    int ones;
    logic pbit;
    e.d = '0;
    e.fe = 1'b0;
    bq.push_back(1'b0);
    for (int i = 0; i < nd; i++) begin
      e.d[i] = d[i];
      bq.push_back(d[i]);
    end
    ones = $countones(e.d);
    pbit = (pm == 2) ? (ones % 2 == 0) : (ones % 2 == 1);
    if (!par_ok) pbit = ~pbit;
    if (pm != 0) bq.push_back(pbit);
    for (int i = 0; i < ns; i++) begin
      bq.push_back(sv[i]);
      if (!sv[i]) e.fe = 1'b1;
    end
    e.pe = (pm != 0) && !par_ok;
    expect_push(w, e);
    foreach (bq[i]) begin
      @(negedge clk);
      if (w == 0) drv_a = bq[i]; else drv_b = bq[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk);
    if (w == 0) drv_a = 1'b1; else drv_b = 1'b1;
  endtask

  initial begin
    #(20 * 95000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b0; rst_bc = 1'b0;
    tx_data_a = '0; wr_a = 1'b0; drv_a = 1'b1; lb_a = 1'b1;
    clr_a = 1'b0; drv_b = 1'b1; clr_b = 1'b0;
    tx_data_c = '0; wr_c = 1'b0; clr_c = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx_a), 32'h1);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_rx_data", 32'(rxd_a), 32'h0);
    chk("rst_ready", 32'(rdy_a), 32'h0);
    chk("rst_flags", 32'({pe_a, fe_a, ov_a}), 32'h0);
    chk("rst_tx_c", 32'(tx_c), 32'h1);
    rst_a = 1'b1;
    rst_bc = 1'b1;
    fork
      begin : br_a
        int t0, n, n0, lat;
        logic [7:0] d;
        exp_t e;
        e.pe = 1'b0; e.fe = 1'b0;
        e.d = 9'h009;
        qa.push_back(e);
        @(negedge clk);
        tx_data_a = 8'h09;
        wr_a = 1'b1;
        @(negedge clk);
        t0 = cyc;
        n = 0;
        while (busy_a && n < 10000) begin
          n++;
          @(negedge clk);
        end
        chk("busy_len_a", 32'(n), 32'(NB_A * CPB));
        chk("rx_rises_a", 32'(rises_a), 32'h1);
        lat = rise_t_a - t0;
        if (lat < 4555 || lat > 4570) begin
          checks++; errors++;
          $display("FAIL rx_latency_a: got %0d, expected ~4560",
                   lat);
        end else checks++;
        repeat (2 * (NB_A * CPB + 1)) @(negedge clk);
        chk("overrun_a", 32'(ov_a), 32'h1);
        chk("ovr_keep_data", 32'(rxd_a), 32'h09);
        wr_a = 1'b0;
        wait_idle_a();
        repeat (5) @(negedge clk);
        pulse_clr(0);
        chk("clr_ready_a", 32'(rdy_a), 32'h0);
        chk("clr_overrun_a", 32'(ov_a), 32'h0);
        chk("clr_keep_data", 32'(rxd_a), 32'h09);

        d = 8'($urandom);
        e.d = {1'b0, d};
        qa.push_back(e);
        n0 = rises_a;
        tx_send_a(d, t0);
        wait_rise(0, n0, 6000);
        d = 8'($urandom);
        tx_send_a(d, t0);
        while (cyc < t0 + DONE_A - 1) @(negedge clk);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        chk("done_clr_ready", 32'(rdy_a), 32'h1);
        chk("done_clr_ovr", 32'(ov_a), 32'h0);
        chk("done_clr_data", 32'(rxd_a), 32'(d));
        pulse_clr(0);

        for (int i = 0; i < 3; i++) begin
          d = 8'($urandom);
          e.d = {1'b0, d};
          qa.push_back(e);
          n0 = rises_a;
          tx_send_a(d, t0);
          wait_rise(0, n0, 6000);
          pulse_clr(0);
        end
        wait_idle_a();

        lb_a = 1'b0;
        drv_a = 1'b1;
        @(negedge clk);
        drv_a = 1'b0;
        repeat (3) @(negedge clk);
        drv_a = 1'b1;
        repeat (10) @(negedge clk);
        chk("glitch_ready", 32'(rdy_a), 32'h0);
        n0 = rises_a;
        drive_frame(0, 9'h055, 8, 1, 1'b1, 1, 2'b11);
        wait_rise(0, n0, 2000);
        pulse_clr(0);

        lb_a = 1'b1;
        tx_send_a(8'($urandom), t0);
        repeat (NB_A * CPB / 2) @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        chk("mid_rst_tx", 32'(tx_a), 32'h1);
        chk("mid_rst_busy", 32'(busy_a), 32'h0);
        chk("mid_rst_rx",
            32'({rxd_a, rdy_a, pe_a, fe_a, ov_a}), 32'h0);
        repeat (2 * NB_A * CPB) @(negedge clk);
        d = 8'($urandom);
        e.d = {1'b0, d};
        qa.push_back(e);
        n0 = rises_a;
        tx_send_a(d, t0);
        wait_rise(0, n0, 6000);
      end
      begin : br_b
        int n0;
        logic [1:0] sv;
        n0 = rises_b;
        drive_frame(1, 9'h0A5, 8, 2, 1'b0, 2, 2'b11);
        wait_rise(1, n0, 2000);
        chk("odd_par_err", 32'(pe_b), 32'h1);
        pulse_clr(1);
        repeat (CPB) @(negedge clk);
        n0 = rises_b;
        drive_frame(1, 9'h03C, 8, 2, 1'b1, 2, 2'b01);
        wait_rise(1, n0, 2000);
        pulse_clr(1);
        chk("fe_clr_ready", 32'(rdy_b), 32'h0);
        chk("fe_hold", 32'(fe_b), 32'h1);
        chk("fe_data_hold", 32'(rxd_b), 32'h3C);
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          sv = 2'($urandom);
          n0 = rises_b;
          drive_frame(1, 9'($urandom & 32'hFF), 8, 2,
                      1'($urandom), 2, sv);
          wait_rise(1, n0, 2000);
          pulse_clr(1);
          repeat (CPB) @(negedge clk);
        end
      end
      begin : br_c
        int t0, n;
        exp_t e;
        e.d = 9'h041; e.pe = 1'b0; e.fe = 1'b0;
        qc.push_back(e);
        @(negedge clk);
        tx_data_c = 7'h41;
        wr_c = 1'b1;
        @(negedge clk);
        wr_c = 1'b0;
        t0 = cyc;
        n = 0;
        while (busy_c && n < 60000) begin
          n++;
          clr_c = (cyc == t0 + DONE_C - 1);
          @(negedge clk);
        end
        clr_c = 1'b0;
        chk("busy_len_c", 32'(n), 32'(NB_C * CPB_C));
        chk("rises_c", 32'(rises_c), 32'h1);
        chk("c_ready", 32'(rdy_c), 32'h1);
        chk("c_overrun", 32'(ov_c), 32'h0);
        chk("c_parity_none", 32'(pe_c), 32'h0);
      end
    join
    repeat (5) @(negedge clk);
    chk("qa_empty", 32'(qa.size()), 32'h0);
    chk("qb_empty", 32'(qb.size()), 32'h0);
    chk("qc_empty", 32'(qc.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
